// File: rtl/fft_spectrum_reader_pkg.sv
// Shared types and constants for the FFT spectrum display reader.
// Holds the controller state encoding, the default geometry of the
// spectrum display and the width helpers derived from it.
package fft_disp_pkg;

    // Reader controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PENDING = 2'd3
    } state_t;

    // Default geometry: 12-bit magnitudes, 128 displayed bins, 9-bit bars
    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_NUM_BINS   = 128;
    localparam int DEF_RD_LAT     = 2;
    localparam int DEF_HEIGHT_W   = 9;
    localparam int DEF_SHIFT      = 3;
    localparam int DEF_MAX_HEIGHT = 400;

    // Ceiling log2; returns the number of bits needed to index 'value' entries
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return bits;
    endfunction

    // Width of a bin index for a spectrum of num_bins entries
    function automatic int bin_idx_w(input int num_bins);
        return clog2(num_bins);
    endfunction

endpackage

// File: rtl/fft_spectrum_reader_bar_dpram.sv
// Simple dual-port bar-height RAM holding both halves of the ping-pong
// buffer. The MSB of each address selects the half; the read port is
// registered so the renderer sees one cycle of latency.
module bar_dpram
    import fft_disp_pkg::*;
#(
    parameter int NUM_BINS = DEF_NUM_BINS,
    parameter int HEIGHT_W = DEF_HEIGHT_W
) (
    input  logic                             clk,
    input  logic                             i_wr_en,
    input  logic [clog2(2*NUM_BINS)-1:0]     i_wr_addr,
    input  logic [HEIGHT_W-1:0]              i_wr_data,
    input  logic [clog2(2*NUM_BINS)-1:0]     i_rd_addr,
    output logic [HEIGHT_W-1:0]              o_rd_data
);

    logic [HEIGHT_W-1:0] r_mem [2*NUM_BINS];
    logic [HEIGHT_W-1:0] r_rd_data;

    // Write port and registered read port
    // NOTE: the array and its read register have no reset so the storage maps
    // onto block RAM; consumers mask the output until valid data exists.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft_spectrum_reader.sv
// Reads one FFT magnitude spectrum per fft_done rising edge, converts each
// bin into a saturated bar height in the back half of a ping-pong buffer,
// tracks the strongest non-DC bin, and swaps the buffer to the renderer
// only at frame start. Also flags a missing or misplaced end-of-burst pulse.
module fft_spectrum_reader
    import fft_disp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_BINS   = DEF_NUM_BINS,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int HEIGHT_W   = DEF_HEIGHT_W,
    parameter int SHIFT      = DEF_SHIFT,
    parameter int MAX_HEIGHT = DEF_MAX_HEIGHT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              fft_done,
    output logic                              fft_data_out_en,
    output logic [ADDR_WIDTH-1:0]             fft_addr_out,
    input  logic [DATA_WIDTH-1:0]             fft_data_out,
    input  logic                              fft_data_out_last,
    input  logic                              frame_start,
    input  logic [bin_idx_w(NUM_BINS)-1:0]    bar_addr,
    output logic [HEIGHT_W-1:0]               bar_height,
    output logic [ADDR_WIDTH-1:0]             peak_bin,
    output logic [DATA_WIDTH-1:0]             peak_mag,
    output logic                              spec_valid,
    output logic                              seq_err,
    output logic                              busy
);

    localparam int IDX_W  = bin_idx_w(NUM_BINS);
    localparam int DCNT_W = (clog2(RD_LAT + 1) < 1) ? 1 : clog2(RD_LAT + 1);

    // Controller state
    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_en;
    logic                    w_busy;

    // Request capture and counters
    logic                    r_done_q;
    logic                    r_req;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [DCNT_W-1:0]       r_drain_cnt;
    logic                    w_done_rise;
    logic                    w_read_start;
    logic                    w_read_last;
    logic                    w_drain_last;
    logic                    w_swap;

    // Read-return alignment
    logic [RD_LAT-1:0]       r_en_pipe;
    logic [ADDR_WIDTH-1:0]   r_addr_pipe [RD_LAT];
    logic                    w_en_d;
    logic [ADDR_WIDTH-1:0]   w_addr_d;

    // Height conversion
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic [HEIGHT_W-1:0]     w_height;

    // Peak tracking and display-side registers
    logic [ADDR_WIDTH-1:0]   r_bk_peak_bin;
    logic [DATA_WIDTH-1:0]   r_bk_peak_mag;
    logic [ADDR_WIDTH-1:0]   r_peak_bin;
    logic [DATA_WIDTH-1:0]   r_peak_mag;
    logic                    r_front;
    logic                    r_spec_valid;
    logic                    r_last_exp;
    logic                    r_seq_err;
    logic [HEIGHT_W-1:0]     w_rd_height;

    assign w_done_rise  = fft_done & ~r_done_q;
    assign w_read_start = (r_state == ST_IDLE) && r_req;
    assign w_read_last  = (r_state == ST_READ) && (r_cnt == ADDR_WIDTH'(NUM_BINS - 1));
    assign w_drain_last = (r_state == ST_DRAIN) && (r_drain_cnt == DCNT_W'(RD_LAT - 1));
    assign w_swap       = (r_state == ST_PENDING) && frame_start;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    // NOTE: w_state_next is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (r_req)        w_state_next = ST_READ;
            ST_READ:    if (w_read_last)  w_state_next = ST_DRAIN;
            ST_DRAIN:   if (w_drain_last) w_state_next = ST_PENDING;
            ST_PENDING: if (frame_start)  w_state_next = ST_IDLE;
            default:                      w_state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs: read enable during READ, busy during READ/DRAIN
    always_comb begin
        w_en   = 1'b0;
        w_busy = 1'b0;
        unique case (r_state)
            ST_READ: begin
                w_en   = 1'b1;
                w_busy = 1'b1;
            end
            ST_DRAIN: w_busy = 1'b1;
            default: ;
        endcase
    end

    // Previous fft_done level; follows the input even in reset so a level
    // held high across reset does not look like a fresh edge afterwards
    always_ff @(posedge clk) begin
        r_done_q <= fft_done;
    end

    // Pending-spectrum request: set by an fft_done edge, consumed on READ entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req <= 1'b0;
        end else if (w_done_rise) begin
            r_req <= 1'b1;
        end else if (w_read_start) begin
            r_req <= 1'b0;
        end
    end

    // Bin counter: walks 0..NUM_BINS-1 in READ and rests at zero elsewhere
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_READ) begin
            r_cnt <= w_read_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Drain counter: covers the RAM latency after the last address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drain_cnt <= '0;
        end else if (r_state == ST_DRAIN) begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
        end else begin
            r_drain_cnt <= '0;
        end
    end

    // Enable delay line aligning each request with its returning sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_pipe <= '0;
        end else begin
            r_en_pipe[0] <= w_en;
            for (int i = 1; i < RD_LAT; i++) begin
                r_en_pipe[i] <= r_en_pipe[i-1];
            end
        end
    end

    // Address delay line; qualified by the enable line so it needs no reset
    always_ff @(posedge clk) begin
        r_addr_pipe[0] <= r_cnt;
        for (int i = 1; i < RD_LAT; i++) begin
            r_addr_pipe[i] <= r_addr_pipe[i-1];
        end
    end

    assign w_en_d   = r_en_pipe[RD_LAT-1];
    assign w_addr_d = r_addr_pipe[RD_LAT-1];

    // Scale the magnitude down and clamp it to the tallest drawable bar
    assign w_shifted = fft_data_out >> SHIFT;
    assign w_height  = (w_shifted > DATA_WIDTH'(MAX_HEIGHT)) ? HEIGHT_W'(MAX_HEIGHT)
                                                             : w_shifted[HEIGHT_W-1:0];

    // Back-buffer peak tracker: strict compare keeps the lowest bin on ties
    always_ff @(posedge clk) begin
        if (rst || w_read_start) begin
            r_bk_peak_bin <= '0;
            r_bk_peak_mag <= '0;
        end else if (w_en_d && (w_addr_d != '0) && (fft_data_out > r_bk_peak_mag)) begin
            r_bk_peak_bin <= w_addr_d;
            r_bk_peak_mag <= fft_data_out;
        end
    end

    // Frame-aligned swap: publish the finished back half and its peak
    always_ff @(posedge clk) begin
        if (rst) begin
            r_front      <= 1'b0;
            r_spec_valid <= 1'b0;
            r_peak_bin   <= '0;
            r_peak_mag   <= '0;
        end else if (w_swap) begin
            r_front      <= ~r_front;
            r_spec_valid <= 1'b1;
            r_peak_bin   <= r_bk_peak_bin;
            r_peak_mag   <= r_bk_peak_mag;
        end
    end

    // End-of-burst check: last must appear exactly one cycle after the final
    // enable and nowhere else; any disagreement latches until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_exp <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_last_exp <= w_read_last;
            if (fft_data_out_last != r_last_exp) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    bar_dpram #(
        .NUM_BINS (NUM_BINS),
        .HEIGHT_W (HEIGHT_W)
    ) u_bar_dpram (
        .clk       (clk),
        .i_wr_en   (w_en_d),
        .i_wr_addr ({~r_front, w_addr_d[IDX_W-1:0]}),
        .i_wr_data (w_height),
        .i_rd_addr ({r_front, bar_addr}),
        .o_rd_data (w_rd_height)
    );

    assign fft_data_out_en = w_en;
    assign fft_addr_out    = r_cnt;
    assign busy            = w_busy;
    assign bar_height      = r_spec_valid ? w_rd_height : '0;
    assign peak_bin        = r_peak_bin;
    assign peak_mag        = r_peak_mag;
    assign spec_valid      = r_spec_valid;
    assign seq_err         = r_seq_err;

endmodule

// File: tb/tb_fft_spectrum_reader.sv
// Directed bench for fft_spectrum_reader with default parameters. A small
// two-cycle-latency RAM model answers the read port and raises the
// end-of-burst pulse; a monitor records enable run lengths and address order.
module tb_fft_spectrum_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fft_done = 1'b0;
    logic        frame_start = 1'b0;
    logic [6:0]  bar_addr = '0;
    logic        fft_data_out_en;
    logic [7:0]  fft_addr_out;
    logic [8:0]  bar_height;
    logic [7:0]  peak_bin;
    logic [11:0] peak_mag;
    logic        spec_valid;
    logic        seq_err;
    logic        busy;

    // FFT output RAM model
    logic [11:0] mem [256];
    logic [11:0] rd_s1 = '0;
    logic [11:0] rd_s2 = '0;
    logic        last_q = 1'b0;
    logic        suppress_last = 1'b0;

    // Monitor state
    int          en_total = 0;
    int          run = 0;
    int          last_run = 0;
    int          addr_bad = 0;
    logic        prev_en = 1'b0;
    logic [7:0]  prev_addr = '0;

    int          total = 0;
    int          bad = 0;

    fft_spectrum_reader dut (
        .clk               (clk),
        .rst               (rst),
        .fft_done          (fft_done),
        .fft_data_out_en   (fft_data_out_en),
        .fft_addr_out      (fft_addr_out),
        .fft_data_out      (rd_s2),
        .fft_data_out_last (last_q),
        .frame_start       (frame_start),
        .bar_addr          (bar_addr),
        .bar_height        (bar_height),
        .peak_bin          (peak_bin),
        .peak_mag          (peak_mag),
        .spec_valid        (spec_valid),
        .seq_err           (seq_err),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Two-stage read latency, last pulse one cycle after the final address
    always @(posedge clk) begin
        rd_s1  <= fft_data_out_en ? mem[fft_addr_out] : 12'd0;
        rd_s2  <= rd_s1;
        last_q <= fft_data_out_en && (fft_addr_out == 8'd127) && !suppress_last;
    end

    // Enable run length and address sequence monitor
    always @(posedge clk) begin
        if (fft_data_out_en === 1'b1) begin
            if (fft_addr_out !== ((prev_en === 1'b1) ? 8'(prev_addr + 8'd1) : 8'd0)) begin
                addr_bad = addr_bad + 1;
            end
            en_total = en_total + 1;
            run      = run + 1;
        end else if (prev_en === 1'b1) begin
            last_run = run;
            run      = 0;
        end
        prev_en   = fft_data_out_en;
        prev_addr = fft_addr_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_ramp(input int step);
        for (int k = 0; k < 256; k++) mem[k] = 12'(step * k);
    endtask

    task automatic load_zero();
        for (int k = 0; k < 256; k++) mem[k] = 12'd0;
    endtask

    // Produce a clean fft_done rising edge; returns on the cycle it rises
    task automatic kick();
        fft_done = 1'b0;
        tick();
        fft_done = 1'b1;
    endtask

    // One-cycle frame_start; returns one cycle after the sampling edge
    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_burst(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_busy_rise"}, 32'(busy), 1);
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_busy_fall"}, 32'(busy), 0);
    endtask

    task automatic read_bar(input string tag, input int idx, input int exp);
        bar_addr = 7'(idx);
        tick();
        check(tag, 32'(bar_height), exp);
    endtask

    initial begin
        int snap;
        int n;

        load_ramp(16);
        repeat (3) tick();
        check("rst_en", 32'(fft_data_out_en), 0);
        check("rst_addr", 32'(fft_addr_out), 0);
        check("rst_bar", 32'(bar_height), 0);
        check("rst_peak_bin", 32'(peak_bin), 0);
        check("rst_peak_mag", 32'(peak_mag), 0);
        check("rst_valid", 32'(spec_valid), 0);
        check("rst_seq_err", 32'(seq_err), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();

        // Ramp spectrum: en two cycles after the edge, 128 ordered addresses
        kick();
        tick();
        check("t1_en_t1", 32'(fft_data_out_en), 0);
        tick();
        check("t1_en_t2", 32'(fft_data_out_en), 1);
        check("t1_addr0", 32'(fft_addr_out), 0);
        wait_burst("t1");
        check("t1_run_len", 32'(last_run), 128);
        check("t1_addr_order", 32'(addr_bad), 0);
        check("t1_valid_pre", 32'(spec_valid), 0);
        read_bar("t1_bar_masked", 10, 0);
        frame();
        check("t1_valid", 32'(spec_valid), 1);
        check("t1_peak_bin", 32'(peak_bin), 127);
        check("t1_peak_mag", 32'(peak_mag), 2032);
        check("t1_seq_ok", 32'(seq_err), 0);
        read_bar("t1_bar10", 10, 20);
        read_bar("t1_bar127", 127, 254);

        // Saturation
        load_zero();
        mem[5] = 12'd4095;
        kick();
        wait_burst("t2");
        frame();
        check("t2_peak_bin", 32'(peak_bin), 5);
        check("t2_peak_mag", 32'(peak_mag), 4095);
        read_bar("t2_bar5_sat", 5, 400);
        read_bar("t2_bar6", 6, 0);

        // Ties keep the lower bin; DC excluded from the peak but still drawn
        load_zero();
        mem[0]  = 12'd4000;
        mem[3]  = 12'd900;
        mem[40] = 12'd900;
        kick();
        wait_burst("t3");
        frame();
        check("t3_peak_bin", 32'(peak_bin), 3);
        check("t3_peak_mag", 32'(peak_mag), 900);
        read_bar("t3_bar3", 3, 112);
        read_bar("t3_bar0_sat", 0, 400);

        // New spectrum arriving while the previous one waits for a frame
        load_ramp(16);
        kick();
        wait_burst("t4a");
        load_ramp(8);
        kick();
        snap = en_total;
        repeat (300) tick();
        check("t4_no_en_pending", 32'(en_total - snap), 0);
        check("t4_busy_pending", 32'(busy), 0);
        check("t4_old_peak", 32'(peak_bin), 3);
        frame();
        check("t4_peak_bin", 32'(peak_bin), 127);
        check("t4_peak_mag", 32'(peak_mag), 2032);
        bar_addr = 7'd10;
        tick();
        check("t4_restart_en", 32'(fft_data_out_en), 1);
        check("t4_bar10", 32'(bar_height), 20);
        wait_burst("t4b");
        frame();
        check("t4b_peak_mag", 32'(peak_mag), 1016);
        read_bar("t4b_bar10", 10, 10);

        // Missing end-of-burst pulse is sticky
        check("t5_seq_before", 32'(seq_err), 0);
        suppress_last = 1'b1;
        load_ramp(16);
        kick();
        wait_burst("t5a");
        check("t5_seq_set", 32'(seq_err), 1);
        frame();
        suppress_last = 1'b0;
        kick();
        wait_burst("t5b");
        frame();
        check("t5_seq_sticky", 32'(seq_err), 1);
        check("t5_peak_mag", 32'(peak_mag), 2032);

        // Reset in the middle of a read burst
        kick();
        n = 0;
        while (!(fft_data_out_en === 1'b1 && fft_addr_out === 8'd60) && n < 300) begin
            tick();
            n++;
        end
        check("t6_reach60", 32'(fft_addr_out), 60);
        rst = 1'b1;
        tick();
        check("t6_en_off", 32'(fft_data_out_en), 0);
        check("t6_valid", 32'(spec_valid), 0);
        check("t6_seq_clr", 32'(seq_err), 0);
        check("t6_peak_bin", 32'(peak_bin), 0);
        check("t6_peak_mag", 32'(peak_mag), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_bar", 32'(bar_height), 0);
        tick();
        rst = 1'b0;
        check("t6_abort_len", 32'(last_run), 61);
        snap = addr_bad;
        kick();
        wait_burst("t6");
        check("t6_run_len", 32'(last_run), 128);
        check("t6_addr_order", 32'(addr_bad - snap), 0);
        check("t6_valid_pre", 32'(spec_valid), 0);
        frame();
        check("t6_valid_post", 32'(spec_valid), 1);
        check("t6_peak_bin_post", 32'(peak_bin), 127);
        read_bar("t6_bar10", 10, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
